data_mem_access_unit: RTL and testbench

Load/store initiator that sits between the MIPS pipeline's MEM stage and the single-port read-first data memory. It accepts one byte/halfword/word request at a time, drives the memory's address/enable/write/output-register controls, and tracks the memory's 1- or 2-cycle read latency. Sub-word stores use read-modify-write because the memory has no byte enables. Load data is lane-extracted and sign- or zero-extended.

---
 rtl/data_mem_access_unit.sv | 249 ++++++++++++++++++++++++
 tb/tb_data_mem_access_unit.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_access_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : data_mem_access_unit
// Brief    : MEM-stage load/store initiator for a single-port read-first data
//            memory; sub-word stores use read-modify-write, loads are
//            lane-extracted and sign/zero-extended.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_access_unit #(
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic [31:0]           rsp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_dataIn,
    output logic                  mem_we,
    output logic                  mem_enable,
    output logic                  mem_re,
    input  logic [31:0]           mem_dataOut
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCESS = 3'd1,
        S_WAIT   = 3'd2,
        S_MERGE  = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    localparam logic [1:0] WAIT_INIT = 2'(READ_LATENCY - 1);
    localparam logic       USE_OREG  = (READ_LATENCY == 2);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    state_t                  state_q, state_d;
    logic [1:0]              cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [1:0]              size_q, size_d;
    logic                    uns_q, uns_d;
    logic [1:0]              lane_q, lane_d;
    logic [31:0]             wdata_q, wdata_d;

    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [31:0]             rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]             mem_dataIn_q, mem_dataIn_d;
    logic                    mem_we_q, mem_we_d;
    logic                    mem_enable_q, mem_enable_d;
    logic                    mem_re_q, mem_re_d;

    logic                    req_misaligned;
    logic                    unused_addr_hi;

    // Upper byte-address bits fall outside the memory; accesses wrap.
    assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

    assign req_misaligned = ((req_size == SZ_HALF) && req_addr[0]) ||
                            (req_size[1] && (req_addr[1:0] != 2'b00));

    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic        uns,
                                                 input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: res = uns ? {24'h0, b} : {{24{b[7]}}, b};
            SZ_HALF: res = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane);
        logic [31:0] res;
        res = word;
        if (size == SZ_HALF) begin
            if (lane[1]) res[31:16] = wdata[15:0];
            else         res[15:0]  = wdata[15:0];
        end else begin
            case (lane)
                2'd0:    res[7:0]   = wdata[7:0];
                2'd1:    res[15:8]  = wdata[7:0];
                2'd2:    res[23:16] = wdata[7:0];
                default: res[31:24] = wdata[7:0];
            endcase
        end
        return res;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 2'd0;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            lane_q       <= 2'b00;
            wdata_q      <= 32'h0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= 32'h0;
            mem_addr_q   <= '0;
            mem_dataIn_q <= 32'h0;
            mem_we_q     <= 1'b0;
            mem_enable_q <= 1'b0;
            mem_re_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_dataIn_q <= mem_dataIn_d;
            mem_we_q     <= mem_we_d;
            mem_enable_q <= mem_enable_d;
            mem_re_q     <= mem_re_d;
        end
    end

    // Outputs are registered: each branch sets the values the next state drives.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        rsp_valid_d  = 1'b0;
        rsp_err_d    = 1'b0;
        rsp_rdata_d  = 32'h0;
        mem_addr_d   = mem_addr_q;
        mem_dataIn_d = mem_dataIn_q;
        mem_we_d     = 1'b0;
        mem_enable_d = 1'b0;
        mem_re_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    lane_d  = req_addr[1:0];
                    wdata_d = req_wdata;
                    if (req_misaligned) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d      = S_ACCESS;
                        mem_enable_d = 1'b1;
                        mem_addr_d   = req_addr[ADDR_WIDTH+1:2];
                        if (req_we && req_size[1]) begin
                            mem_we_d     = 1'b1;
                            mem_dataIn_d = req_wdata;
                        end
                    end
                end
            end

            S_ACCESS: begin
                if (we_q && size_q[1]) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    state_d  = S_WAIT;
                    cnt_d    = WAIT_INIT;
                    mem_re_d = USE_OREG;
                end
            end

            S_WAIT: begin
                // mem_dataOut is valid in the last WAIT cycle and consumed directly.
                if (cnt_q == 2'd0) begin
                    if (!we_q) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = lane_extract(mem_dataOut, size_q, uns_q, lane_q);
                    end else begin
                        state_d      = S_MERGE;
                        mem_enable_d = 1'b1;
                        mem_we_d     = 1'b1;
                        mem_dataIn_d = lane_merge(mem_dataOut, wdata_q, size_q, lane_q);
                    end
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end

            S_MERGE: begin
                state_d     = S_RESP;
                rsp_valid_d = 1'b1;
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign req_ready  = (state_q == S_IDLE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_dataIn = mem_dataIn_q;
    assign mem_we     = mem_we_q;
    assign mem_enable = mem_enable_q;
    assign mem_re     = mem_re_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_access_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_access_unit
// Brief    : Scoreboard bench with a behavioural read-first memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_access_unit;

    localparam int AW    = 10;
    localparam int RL    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_err;
    logic [31:0]   rsp_rdata;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_dataIn;
    logic          mem_we;
    logic          mem_enable;
    logic          mem_re;
    logic [31:0]   mem_dataOut;

    data_mem_access_unit #(.ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .mem_addr(mem_addr), .mem_dataIn(mem_dataIn), .mem_we(mem_we),
        .mem_enable(mem_enable), .mem_re(mem_re), .mem_dataOut(mem_dataOut)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int i);
        if (i == 8)  return 32'h11223344;
        if (i == 16) return 32'hA5A5A5A5;
        return (32'(i) * 32'h00010003) ^ 32'hC3A50F00;
    endfunction

    // Behavioural single-port read-first memory with optional output register
    logic [31:0] mem [0:DEPTH-1];
    logic [31:0] rd_raw, dout_q;
    int          init_cnt = 0;
    int          wr_cnt = 0;
    int          en_cnt = 0;
    int          last_wr_cyc = -1;
    logic [AW-1:0] last_wr_addr = '0;
    logic [31:0]   last_wr_data = 32'h0;

    always @(posedge clk) begin
        if (reset && init_cnt < DEPTH) begin
            mem[init_cnt] <= init_word(init_cnt);
            init_cnt      <= init_cnt + 1;
        end else if (mem_enable) begin
            en_cnt <= en_cnt + 1;
            rd_raw <= mem[mem_addr];
            if (mem_we) begin
                mem[mem_addr] <= mem_dataIn;
                wr_cnt        <= wr_cnt + 1;
                last_wr_cyc   <= cyc;
                last_wr_addr  <= mem_addr;
                last_wr_data  <= mem_dataIn;
            end
        end
        if (mem_re) dout_q <= rd_raw;
    end

    assign mem_dataOut = (RL == 2) ? dout_q : rd_raw;

    // Reference model
    logic [31:0] ref_mem [0:DEPTH-1];

    function automatic logic [31:0] ld_ext(input logic [31:0] w, input logic [1:0] sz,
                                           input logic u, input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*a +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        if (sz[1])         return w;
        if (sz == 2'b01)   return u ? {16'h0, h} : {{16{h[15]}}, h};
        return u ? {24'h0, b} : {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] st_merge(input logic [31:0] w, input logic [31:0] d,
                                             input logic [1:0] sz, input logic [1:0] a);
        logic [31:0] r;
        r = w;
        if (sz[1])            r = d;
        else if (sz == 2'b01) r[16*a[1] +: 16] = d[15:0];
        else                  r[8*a +: 8] = d[7:0];
        return r;
    endfunction

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t sb[$];

    always @(negedge clk) begin
        if (!reset && rsp_valid) begin
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: rsp_valid=1 with nothing outstanding at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (rsp_err !== e.err || rsp_rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL %s data: got err=%0b rdata=%08h, expected err=%0b rdata=%08h",
                             e.name, rsp_err, rsp_rdata, e.err, e.rdata);
                end
                checks++;
                if (cyc - e.acc != e.lat) begin
                    errors++;
                    $display("FAIL %s latency: got cycle %0d, expected cycle %0d",
                             e.name, cyc - e.acc, e.lat);
                end
            end
        end
    end

    function automatic exp_t make_exp(input logic we, input logic [1:0] sz, input logic u,
                                      input logic [31:0] addr, input logic [31:0] wd,
                                      input string name);
        exp_t e;
        logic [AW-1:0] idx;
        idx    = addr[AW+1:2];
        e.name = name;
        e.acc  = 0;
        e.err  = 1'b0;
        e.rdata = 32'h0;
        if ((sz == 2'b01 && addr[0]) || (sz[1] && addr[1:0] != 2'b00)) begin
            e.err = 1'b1;
            e.lat = 1;
        end else if (we) begin
            ref_mem[idx] = st_merge(ref_mem[idx], wd, sz, addr[1:0]);
            e.lat = sz[1] ? 2 : 3 + RL;
        end else begin
            e.rdata = ld_ext(ref_mem[idx], sz, u, addr[1:0]);
            e.lat   = 2 + RL;
        end
        return e;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: %0d responses outstanding, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic u,
                          input logic [31:0] addr, input logic [31:0] wd, input string name);
        exp_t e;
        wait_ready();
        e = make_exp(we, sz, u, addr, wd, name);
        req_we       = we;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = addr;
        req_wdata    = wd;
        req_valid    = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        e.acc     = cyc - 1;
        last_acc  = e.acc;
        sb.push_back(e);
        wait_drain(name);
    endtask

    task automatic test_reset();
        int n = 0;
        reset = 1'b1;
        while (init_cnt < DEPTH && n < DEPTH + 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rsp: ready=%0b valid=%0b err=%0b rdata=%08h, expected 1 0 0 0",
                     req_ready, rsp_valid, rsp_err, rsp_rdata);
        end
        checks++;
        if (mem_enable !== 1'b0 || mem_we !== 1'b0 || mem_re !== 1'b0 ||
            mem_addr !== '0 || mem_dataIn !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem: en=%0b we=%0b re=%0b addr=%0h din=%08h, expected all 0",
                     mem_enable, mem_we, mem_re, mem_addr, mem_dataIn);
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %0b, expected 1", req_ready);
        end
    endtask

    task automatic test_word_access();
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, "sw_0x10");
        checks++;
        if (last_wr_addr !== 10'd4 || last_wr_data !== 32'hDEADBEEF || last_wr_cyc != last_acc + 1) begin
            errors++;
            $display("FAIL sw_write: addr=%0h data=%08h cycle=%0d, expected 4 DEADBEEF 1",
                     last_wr_addr, last_wr_data, last_wr_cyc - last_acc);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "lw_0x10");
    endtask

    task automatic test_byte();
        do_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h12345680, "sb_0x21");
        checks++;
        if (mem[8] !== 32'h11228044 || last_wr_cyc != last_acc + 2 + RL) begin
            errors++;
            $display("FAIL sb_merge: word=%08h cycle=%0d, expected 11228044 at cycle %0d",
                     mem[8], last_wr_cyc - last_acc, 2 + RL);
        end
        do_req(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, "lb_0x21");
        do_req(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, "lbu_0x21");
        do_req(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, "lb_0x20");
    endtask

    task automatic test_half();
        do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h9999ABCD, "sh_0x22");
        checks++;
        if (mem[8] !== 32'hABCD8044) begin
            errors++;
            $display("FAIL sh_merge: word=%08h, expected ABCD8044", mem[8]);
        end
        do_req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, "lh_0x22");
        do_req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, "lhu_0x22");
        do_req(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, "lh_0x20");
        do_req(1'b0, 2'b00, 1'b1, 32'h23, 32'h0, "lbu_0x23");
        do_req(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, "lw_size3_0x20");
    endtask

    task automatic test_misaligned();
        int en0;
        logic [31:0] w0;
        en0 = en_cnt;
        w0  = mem[0];
        do_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, "lw_mis_0x13");
        do_req(1'b0, 2'b01, 1'b0, 32'h01, 32'h0, "lh_mis_0x01");
        do_req(1'b1, 2'b10, 1'b0, 32'h02, 32'h77777777, "sw_mis_0x02");
        do_req(1'b1, 2'b01, 1'b0, 32'h03, 32'h7777, "sh_mis_0x03");
        checks++;
        if (en_cnt != en0 || mem[0] !== w0) begin
            errors++;
            $display("FAIL mis_no_access: enables=%0d word0=%08h, expected 0 enables and %08h",
                     en_cnt - en0, mem[0], w0);
        end
    endtask

    task automatic test_wrap();
        do_req(1'b1, 2'b10, 1'b0, 32'h1000, 32'hCAFEF00D, "sw_wrap_0x1000");
        checks++;
        if (last_wr_addr !== 10'd0 || mem[0] !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL wrap_addr: addr=%0h word0=%08h, expected 0 CAFEF00D", last_wr_addr, mem[0]);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, "lw_0x0");
        do_req(1'b1, 2'b00, 1'b0, 32'hFFFFFFFF, 32'h7E, "sb_wrap_top");
        checks++;
        if (mem[DEPTH-1][31:24] !== 8'h7E) begin
            errors++;
            $display("FAIL wrap_top_byte: got %02h, expected 7E", mem[DEPTH-1][31:24]);
        end
        do_req(1'b0, 2'b00, 1'b0, 32'h00000FFF, 32'h0, "lb_0xFFF");
    endtask

    task automatic test_back_to_back();
        exp_t e1, e2;
        wait_ready();
        e1 = make_exp(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "b2b_first");
        e2 = make_exp(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, "b2b_second");
        req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0; req_valid = 1'b1;
        @(posedge clk);
        #1;
        e1.acc = cyc - 1;
        e2.acc = e1.acc + 3 + RL;
        sb.push_back(e1);
        sb.push_back(e2);
        // Requester holds the first request; fields change once it is taken.
        req_size = 2'b00; req_unsigned = 1'b1;
        repeat (3 + RL) @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_drain("b2b");
    endtask

    task automatic test_random();
        logic        we, u;
        logic [1:0]  sz;
        logic [31:0] a, d;
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            u  = 1'($urandom_range(0, 1));
            a  = ($urandom & 32'hFFFF_F000) | 32'h100 | 32'($urandom_range(0, 31));
            d  = $urandom;
            do_req(we, sz, u, a, d, "random");
        end
    endtask

    task automatic test_reset_mid();
        int wr0, bad;
        wait_ready();
        wr0 = wr_cnt;
        req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h40; req_wdata = 32'h55; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_immediate: ready=%0b valid=%0b we=%0b, expected 1 0 0",
                     req_ready, rsp_valid, mem_we);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || mem_we !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || wr_cnt != wr0 || mem[16] !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL reset_mid_no_write: bad_cycles=%0d writes=%0d word=%08h, expected 0 0 A5A5A5A5",
                     bad, wr_cnt - wr0, mem[16]);
        end
    endtask

    initial begin
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        reset        = 1'b1;
        test_reset();
        test_word_access();
        test_byte();
        test_half();
        test_misaligned();
        test_wrap();
        test_back_to_back();
        test_random();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
